// File: rtl/chan_packet_snap_ctrl_if.sv
// Snapshot BRAM write port shared between the snapshot controller (master) and the BRAM wrapper (slave).
// Widths must match the DATA_WIDTH/ADDR_WIDTH of the controller instance it connects to.
interface chan_packet_snap_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_data;
  logic                  bram_we;

  modport master (
    output bram_addr,
    output bram_data,
    output bram_we
  );

  modport slave (
    input bram_addr,
    input bram_data,
    input bram_we
  );
endinterface

// File: rtl/chan_packet_snap_ctrl.sv
// Channel-packet snapshot controller: arms on a rising start bit, captures 2**ADDR_WIDTH valid samples into BRAM.
// Define CHAN_PACKET_SNAP_SYNC_EN to start each capture after the first sync_in pulse seen while armed.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a start rising edge; count keeps last value
// ST_ARMED   | start seen; waiting for trigger (next cycle, or sync_in)
// ST_CAPTURE | writing each valid sample to BRAM at address count
// ST_DONE    | full snapshot captured; done asserted until re-armed
module chan_packet_snap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [31:0]             start_reg,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  input  logic                    sync_in,
  chan_packet_snap_ctrl_if.master bram,
  output logic [31:0]             status_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [16:0] CAP_LAST = 17'((1 << ADDR_WIDTH) - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [16:0]           count;
  logic                  start_d;
  logic                  start_rise;
  logic                  abort;
  logic                  trigger;
  logic                  cap_write;
  logic                  cap_last;
  logic                  busy;
  logic                  armed;
  logic                  done;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [DATA_WIDTH-1:0] bram_data_q;
  logic                  bram_we_q;

  assign start_rise = start_reg[0] & ~start_d;
  assign abort      = start_reg[1];

`ifdef CHAN_PACKET_SNAP_SYNC_EN
  logic unused_start_bits;
  assign unused_start_bits = &{1'b0, start_reg[31:2]};
  assign trigger = sync_in;
`else
  logic unused_start_bits;
  assign unused_start_bits = &{1'b0, start_reg[31:2], sync_in};
  assign trigger = 1'b1;
`endif

  assign busy  = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign armed = (state == ST_ARMED);
  assign done  = (state == ST_DONE);

  // Abort outranks the capture write, including the one that would complete the snapshot.
  assign cap_write = (state == ST_CAPTURE) && !abort && data_valid;
  assign cap_last  = cap_write && (count == CAP_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_rise) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort)        state_nxt = ST_IDLE;
        else if (trigger) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (cap_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start_rise) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The edge detector keeps sampling through reset so a start bit held high across reset is not seen as a new edge.
  always_ff @(posedge user_clk) begin
    start_d <= start_reg[0];
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      count <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE) && start_rise) begin
      count <= '0;
    end else if (cap_write) begin
      count <= count + 17'd1;
    end
  end

  // Address/data hold their last value between writes; only bram_we qualifies them.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
    end else begin
      bram_we_q <= cap_write;
      if (cap_write) begin
        bram_addr_q <= count[ADDR_WIDTH-1:0];
        bram_data_q <= data_in;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      status_out <= '0;
    end else begin
      status_out <= {done, busy, armed, 12'd0, count};
    end
  end

  assign bram.bram_we   = bram_we_q;
  assign bram.bram_addr = bram_addr_q;
  assign bram.bram_data = bram_data_q;

endmodule
